fade_seq: RTL

- Frame scheduler for the fader -> fade_ifft -> win -> linterp chain.
- Issues the one-shot IFFT configuration over a proper AXI-Stream handshake.
- Generates the periodic fader start pulse and the t_index timebase, and throttles starts against frames still in flight through the IFFT.
- Drains cleanly on disable and counts IFFT framing errors.

---
 rtl/fade_pkg.sv | 18 +
 rtl/fade_credit.sv | 36 +++
 rtl/fade_seq.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/fade_pkg.sv
// Shared types and constants for the fade frame scheduler.
package fade_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CFG   = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } seq_state_t;

    localparam int CFG_W          = 16;
    localparam int DEFAULT_PERIOD = 1024;

    function automatic logic [CFG_W-1:0] pack_cfg(input logic [9:0] scale, input logic fwd_inv);
        return {5'd0, scale, fwd_inv};
    endfunction

endpackage

// File: rtl/fade_credit.sv
// Frames-in-flight tracker between fader start and IFFT frame end.
module fade_credit #(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       dec,
    output logic [3:0] count,
    output logic       full,
    output logic       empty,
    output logic       spurious
);
    logic [3:0] count_r;
    logic       dec_ok_s;

    assign empty    = (count_r == 4'd0);
    assign full     = (count_r >= 4'(MAX_OUTSTANDING));
    assign spurious = dec & empty;
    assign dec_ok_s = dec & ~empty;
    assign count    = count_r;

    // A frame end with nothing in flight is ignored here and reported via spurious
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= 4'd0;
        end else if (inc && !dec_ok_s) begin
            count_r <= count_r + 4'd1;
        end else if (dec_ok_s && !inc) begin
            count_r <= count_r - 4'd1;
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/fade_seq.sv
// Frame scheduler: one-shot IFFT config handshake, periodic fader start with
// in-flight throttling, drain on disable and IFFT framing-error counting.
module fade_seq #(
    parameter int TW              = 25,
    parameter int PW              = 10,
    parameter int MAX_OUTSTANDING = 2,
    parameter int CFG_W           = fade_pkg::CFG_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             reconfig,
    input  logic [PW-1:0]    period,
    input  logic [9:0]       scale,
    input  logic             fwd_inv,
    output logic [CFG_W-1:0] cfg_tdata,
    output logic             cfg_tvalid,
    input  logic             cfg_tready,
    input  logic             out_last,
    input  logic             evt_tlast_unexpected,
    input  logic             evt_tlast_missing,
    output logic             start,
    output logic [TW-1:0]    t_index,
    output logic [3:0]       outstanding,
    output logic [7:0]       err_count,
    output logic [1:0]       state,
    output logic             busy
);
    import fade_pkg::*;

    seq_state_t       state_r;
    logic [PW-1:0]    cnt_r;
    logic [PW-1:0]    reload_s;
    logic [CFG_W-1:0] cfg_tdata_r;
    logic             cfg_tvalid_r;
    logic             start_r;
    logic [TW-1:0]    t_index_r;
    logic [7:0]       err_r;
    logic             fire_s;
    logic             full_s;
    logic             empty_s;
    logic             spurious_s;
    logic [3:0]       outstanding_s;
    logic             err_evt_s;

    fade_credit #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_credit (
        .clk      (clk),
        .reset    (reset),
        .inc      (fire_s),
        .dec      (out_last),
        .count    (outstanding_s),
        .full     (full_s),
        .empty    (empty_s),
        .spurious (spurious_s)
    );

    // Periods below 2 behave as 2; the counter runs from period-1 down to 0
    always_comb begin
        reload_s = {PW{1'b0}};
        if (period < PW'(2)) begin
            reload_s = PW'(1);
        end else begin
            reload_s = period - PW'(1);
        end
    end

    // A returning frame frees its slot in the same cycle a deferred start is due
    assign fire_s    = (state_r == RUN) && (cnt_r == {PW{1'b0}}) && (!full_s || out_last);
    assign err_evt_s = evt_tlast_unexpected | evt_tlast_missing | spurious_s;

    // Sequencer state, config handshake, start pulse and timebase
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= CFG;
            cfg_tvalid_r <= 1'b0;
            cfg_tdata_r  <= {CFG_W{1'b0}};
            start_r      <= 1'b0;
            t_index_r    <= {TW{1'b0}};
            cnt_r        <= {PW{1'b0}};
        end else begin
            start_r <= fire_s;
            if (fire_s) begin
                t_index_r <= t_index_r + TW'(1);
            end
            case (state_r)
                CFG: begin
                    if (!cfg_tvalid_r) begin
                        cfg_tvalid_r <= 1'b1;
                        cfg_tdata_r  <= CFG_W'(pack_cfg(scale, fwd_inv));
                    end else if (cfg_tready) begin
                        cfg_tvalid_r <= 1'b0;
                        cnt_r        <= reload_s;
                        state_r      <= enable ? RUN : IDLE;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        state_r <= DRAIN;
                    end
                    if (fire_s) begin
                        cnt_r <= reload_s;
                    end else if (cnt_r != {PW{1'b0}}) begin
                        cnt_r <= cnt_r - PW'(1);
                    end
                end
                DRAIN: begin
                    if (empty_s) begin
                        state_r <= IDLE;
                    end
                end
                IDLE: begin
                    if (reconfig) begin
                        state_r      <= CFG;
                        cfg_tvalid_r <= 1'b1;
                        cfg_tdata_r  <= CFG_W'(pack_cfg(scale, fwd_inv));
                    end else if (enable) begin
                        state_r <= RUN;
                        cnt_r   <= reload_s;
                    end
                end
                default: begin
                    state_r <= CFG;
                end
            endcase
        end
    end

    // Saturating framing-error count, at most one step per cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_r <= 8'd0;
        end else if (err_evt_s && (err_r != 8'hFF)) begin
            err_r <= err_r + 8'd1;
        end else begin
            err_r <= err_r;
        end
    end

    assign cfg_tdata   = cfg_tdata_r;
    assign cfg_tvalid  = cfg_tvalid_r;
    assign start       = start_r;
    assign t_index     = t_index_r;
    assign outstanding = outstanding_s;
    assign err_count   = err_r;
    assign state       = state_r;
    assign busy        = (state_r != IDLE);

endmodule
